// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned Q_DEPTH_DEF = 2;
  localparam int unsigned PC_INC      = 4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    KILL
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] data;
  } inst_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Small synchronous FIFO holding fetched instructions with their PC.
// Depth must be a power of two so the pointers wrap naturally.
module ifetch_queue import ifetch_pkg::*; #(
  parameter int unsigned Depth = Q_DEPTH_DEF,
  parameter type entry_t = inst_entry_t,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output logic            head_valid_o,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o
);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              full, push_ok, pop_ok;

  assign full         = (count_q == CntW'(Depth));
  assign head_valid_o = (count_q != '0);
  assign pop_ok       = pop_i & head_valid_o;
  assign push_ok      = push_i & (~full | pop_ok);
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  // Flush wins over push and pop; pointers restart at zero.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, one outstanding imem request, 2-entry queue.
// Define IFETCH_ALIGN_CHECK_EN to add the misalign_err_o pulse on misaligned redirects.
module ifetch_unit import ifetch_pkg::*; #(
  parameter int unsigned         ADDR_W   = ADDR_W_DEF,
  parameter int unsigned         DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         Q_DEPTH  = Q_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DATA_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic [ADDR_W-1:0] inst_pc_o
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic              misalign_err_o
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  localparam int unsigned CntW = $clog2(Q_DEPTH + 1);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q, req_pc_q;
  logic [ADDR_W-1:0] redirect_pc_aligned;
  logic [CntW-1:0]   q_count;
  logic              q_full, req_fire, rsp_accept, pop;
  fetch_entry_t      push_entry, head_entry;

  assign redirect_pc_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign q_full              = (q_count == CntW'(Q_DEPTH));

  // A redirect kills the request in its own cycle so no stale-PC fetch is ever accepted.
  assign imem_req_valid_o = ~rst & (state_q == REQ) & ~q_full & ~redirect_valid_i;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;
  assign rsp_accept       = (state_q == WAIT) & imem_rsp_valid_i & ~redirect_valid_i;
  assign pop              = inst_valid_o & inst_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else if (redirect_valid_i) begin
      pc_q <= redirect_pc_aligned;
      // An outstanding request whose response is not here yet must be absorbed in KILL.
      if (imem_rsp_valid_i)      state_q <= REQ;
      else if (state_q != REQ)   state_q <= KILL;
    end else begin
      case (state_q)
        REQ: begin
          if (req_fire) begin
            state_q  <= WAIT;
            req_pc_q <= pc_q;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            state_q <= REQ;
            pc_q    <= pc_q + ADDR_W'(PC_INC);
          end
        end
        KILL: begin
          if (imem_rsp_valid_i) state_q <= REQ;
        end
        default: state_q <= REQ;
      endcase
    end
  end

  assign push_entry.pc   = req_pc_q;
  assign push_entry.data = imem_rsp_data_i;

  ifetch_queue #(
    .Depth   (Q_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid_i),
    .push_i       (rsp_accept),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_valid_o (inst_valid_o),
    .head_o       (head_entry),
    .count_o      (q_count)
  );

  assign inst_data_o = head_entry.data;
  assign inst_pc_o   = head_entry.pc;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= redirect_valid_i & (|redirect_pc_i[1:0]);
  end

  assign misalign_err_o = misalign_q;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc_i[1:0];
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// against a stream-level reference model and a one-outstanding memory model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  ifetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC),
    .Q_DEPTH  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_data_o      (inst_data),
    .inst_pc_o        (inst_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .misalign_err_o   (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 0;

  // Reference model: next PC the fetcher should request and next PC decode should see.
  logic [31:0] exp_fetch_pc, exp_dec_pc, rsp_addr;
  bit          pending, stale;
  int          wcnt;

  // Per-cycle samples taken just before the active edge.
  bit          s_fire, s_pop, s_double, s_req_on_redir, s_hold_chk, s_hold_ok;
  logic [31:0] s_fire_addr, s_pop_pc, s_pop_data, s_exp_fetch, s_exp_dec;
  bit          hold_armed;
  logic [31:0] h_pc, h_data;
  bit          mis_exp, s_mis, s_mis_exp;
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_data_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    #2;
    s_fire         = imem_req_valid & imem_req_ready;
    s_fire_addr    = imem_req_addr;
    s_pop          = inst_valid & inst_ready;
    s_pop_pc       = inst_pc;
    s_pop_data     = inst_data;
    s_req_on_redir = imem_req_valid & redirect_valid;
    s_double       = s_fire & pending;
    s_exp_fetch    = exp_fetch_pc;
    s_exp_dec      = exp_dec_pc;
    s_hold_chk     = hold_armed;
    s_hold_ok      = (inst_valid === 1'b1) && (inst_pc === h_pc) && (inst_data === h_data);
    hold_armed     = (inst_valid === 1'b1) && !inst_ready && !redirect_valid && !rst;
    h_pc           = inst_pc;
    h_data         = inst_data;
`ifdef IFETCH_ALIGN_CHECK_EN
    s_mis          = misalign_err;
`else
    s_mis          = 1'b0;
`endif
    s_mis_exp      = mis_exp;
    mis_exp        = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (rst) begin
      exp_fetch_pc = RESET_PC;
      exp_dec_pc   = RESET_PC;
      pending      = 1'b0;
      stale        = 1'b0;
    end else begin
      if (s_pop) begin
        pop_log.push_back(s_pop_pc);
        pop_data_log.push_back(s_pop_data);
        exp_dec_pc = exp_dec_pc + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (!stale && !redirect_valid) exp_fetch_pc = exp_fetch_pc + 32'd4;
        pending = 1'b0;
        stale   = 1'b0;
      end
      if (s_fire) begin
        req_log.push_back(s_fire_addr);
        pending  = 1'b1;
        stale    = 1'b0;
        wcnt     = mem_lat;
        rsp_addr = s_fire_addr;
      end
      if (redirect_valid) begin
        exp_fetch_pc = {redirect_pc[31:2], 2'b00};
        exp_dec_pc   = {redirect_pc[31:2], 2'b00};
        if (pending) stale = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pending) begin
      if (wcnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(rsp_addr);
      end else begin
        wcnt = wcnt - 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    req_log.delete();
    pop_log.delete();
    pop_data_log.delete();
  endtask

  task automatic run_until_pops(input int n, input string name);
    int guard = 0;
    while (pop_log.size() < n && guard < 100) begin
      tick();
      guard++;
    end
    n_checks++;
    if (pop_log.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: pops=%0d required=%0d", name, pop_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got=%b exp=0", imem_req_valid);
    end
    do_reset();
    #1;
    n_checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_queue: valid=%b pc=%h data=%h exp 0/0/0", inst_valid, inst_pc, inst_data);
    end
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h exp 1/%h", imem_req_valid, imem_req_addr,
               RESET_PC);
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    n_checks++;
    if (misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_misalign: got=%b exp=0", misalign_err);
    end
`endif
  endtask

  task automatic test_basic();
    mem_lat = 0;
    do_reset();
    tick();
    #1;
    n_checks++;
    if ({inst_valid, imem_req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_rsp_cycle: inst_valid=%b req_valid=%b exp 0/0", inst_valid,
               imem_req_valid);
    end
    tick();
    #1;
    n_checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, memf(32'h0)}) begin
      n_fail++;
      $display("FAIL basic_latency: valid=%b pc=%h data=%h exp 1/0/%h", inst_valid, inst_pc,
               inst_data, memf(32'h0));
    end
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL basic_second_req: valid=%b addr=%h exp 1/4", imem_req_valid, imem_req_addr);
    end
    run_until_pops(3, "basic");
    for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
      n_checks++;
      if (pop_log[i] !== 32'(4 * i) || pop_data_log[i] !== memf(32'(4 * i))) begin
        n_fail++;
        $display("FAIL basic_stream[%0d]: pc=%h data=%h exp %h/%h", i, pop_log[i],
                 pop_data_log[i], 32'(4 * i), memf(32'(4 * i)));
      end
      n_checks++;
      if (req_log[i] !== 32'(4 * i)) begin
        n_fail++; $display("FAIL basic_req_addr[%0d]: got=%h exp=%h", i, req_log[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_full();
    mem_lat = 0;
    do_reset();
    inst_ready = 1'b0;
    repeat (8) tick();
    #1;
    n_checks++;
    if ({inst_valid, inst_pc, imem_req_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_stall: inst_valid=%b pc=%h req_valid=%b exp 1/0/0", inst_valid,
               inst_pc, imem_req_valid);
    end
    n_checks++;
    if (req_log.size() != 2) begin
      n_fail++; $display("FAIL full_req_count: got=%0d exp=2", req_log.size());
    end
    inst_ready = 1'b1;
    run_until_pops(2, "full");
    repeat (3) tick();
    n_checks++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
      n_fail++; $display("FAIL full_drain: first pops wrong, count=%0d exp 0,4", pop_log.size());
    end
    n_checks++;
    if (req_log.size() < 3 || req_log[2] !== 32'h8) begin
      n_fail++; $display("FAIL full_resume: reqs=%0d, third req addr not 8", req_log.size());
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 1;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_rsp_valid, imem_req_valid, inst_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL redir_wait_kill: rsp=%b req_valid=%b inst_valid=%b exp 1/0/0",
               imem_rsp_valid, imem_req_valid, inst_valid);
    end
    tick();
    #1;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL redir_wait_next: req_valid=%b addr=%h inst_valid=%b exp 1/100/0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
    mem_lat = 0;
    run_until_pops(1, "redir_wait");
    n_checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h100 || pop_data_log[0] !== memf(32'h100)) begin
      n_fail++; $display("FAIL redir_wait_stream: first pop is not pc 100 with its data");
    end
  endtask

  task automatic test_redirect_same();
    mem_lat = 0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    n_checks++;
    if ({imem_rsp_valid, imem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL redir_same_cycle: rsp=%b req_valid=%b exp 1/0", imem_rsp_valid,
               imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h200, 1'b0}) begin
      n_fail++;
      $display("FAIL redir_same_next: req_valid=%b addr=%h inst_valid=%b exp 1/200/0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
    run_until_pops(1, "redir_same");
    n_checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
      n_fail++; $display("FAIL redir_same_stream: first pop is not pc 200");
    end
  endtask

  task automatic test_stall();
    mem_lat = 0;
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b addr=%h exp 1/0", i, imem_req_valid,
                 imem_req_addr);
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_redir_suppress: req_valid=%b exp 0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL stall_redir_addr: valid=%b addr=%h exp 1/300", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    run_until_pops(1, "stall");
    n_checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h300) begin
      n_fail++; $display("FAIL stall_stream: first pop is not pc 300");
    end
  endtask

  task automatic test_align();
    mem_lat = 0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL align_addr: valid=%b addr=%h exp 1/100", imem_req_valid, imem_req_addr);
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    n_checks++;
    if (misalign_err !== 1'b1) begin
      n_fail++; $display("FAIL misalign_pulse: got=%b exp=1", misalign_err);
    end
    tick();
    #1;
    n_checks++;
    if (misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL misalign_one_cycle: got=%b exp=0", misalign_err);
    end
`endif
  endtask

  task automatic test_rst_wait();
    mem_lat = 0;
    do_reset();
    inst_ready = 1'b0;
    tick();
    tick();
    mem_lat = 2;
    tick();
    #1;
    n_checks++;
    if ({inst_valid, imem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_wait_setup: inst_valid=%b req_valid=%b exp 1/0", inst_valid,
               imem_req_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_wait_restart: req_valid=%b addr=%h inst_valid=%b exp 1/%h/0",
               imem_req_valid, imem_req_addr, inst_valid, RESET_PC);
    end
    mem_lat = 0;
    inst_ready = 1'b1;
    pop_log.delete();
    run_until_pops(1, "rst_wait");
    n_checks++;
    if (pop_log.size() < 1 || pop_log[0] !== RESET_PC) begin
      n_fail++; $display("FAIL rst_wait_stream: first pop after reset is not RESET_PC");
    end
  endtask

  task automatic test_random();
    int n_pops = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      mem_lat        = $urandom_range(0, 2);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      else                           redirect_pc = $urandom;
      tick();
      if (s_pop) begin
        n_pops++;
        n_checks++;
        if (s_pop_pc !== s_exp_dec || s_pop_data !== memf(s_exp_dec)) begin
          n_fail++;
          $display("FAIL rand_pop cyc=%0d: pc=%h data=%h exp %h/%h", cyc, s_pop_pc, s_pop_data,
                   s_exp_dec, memf(s_exp_dec));
        end
      end
      if (s_fire) begin
        n_checks++;
        if (s_fire_addr !== s_exp_fetch || s_double) begin
          n_fail++;
          $display("FAIL rand_req cyc=%0d: addr=%h exp %h, second outstanding=%b", cyc,
                   s_fire_addr, s_exp_fetch, s_double);
        end
      end
      n_checks++;
      if (s_req_on_redir) begin
        n_fail++; $display("FAIL rand_redir_req cyc=%0d: req_valid high during redirect", cyc);
      end
      if (s_hold_chk) begin
        n_checks++;
        if (!s_hold_ok) begin
          n_fail++; $display("FAIL rand_hold cyc=%0d: head changed while stalled", cyc);
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      n_checks++;
      if (s_mis !== s_mis_exp) begin
        n_fail++; $display("FAIL rand_misalign cyc=%0d: got=%b exp=%b", cyc, s_mis, s_mis_exp);
      end
`endif
    end
    redirect_valid = 1'b0;
    n_checks++;
    if (n_pops < 200) begin
      n_fail++; $display("FAIL rand_progress: pops=%0d required>=200", n_pops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_redirect_wait();
    test_redirect_same();
    test_stall();
    test_align();
    test_rst_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
